// File: rtl/weight_mem_loader.sv
// Weight memory loader: streams weight words into one neuron's weight memory
// of this layer, in address order, then pulses done.
module weight_mem_loader #(
  parameter int unsigned layerNo      = 1,
  parameter int unsigned numNeurons   = 64,
  parameter int unsigned numWeight    = 784,
  parameter int unsigned addressWidth = 10,
  parameter int unsigned dataWidth    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             cfg_layer,
  input  logic [31:0]             cfg_neuron,
  input  logic                    s_valid,
  input  logic [dataWidth-1:0]    s_data,
  output logic                    s_ready,
  output logic                    wen,
  output logic [numNeurons-1:0]   wsel,
  output logic [addressWidth-1:0] waddr,
  output logic [dataWidth-1:0]    wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // One spare bit so the count can reach numWeight without wrapping.
  localparam int unsigned CntW = addressWidth + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CntW-1:0]         count_q;
  logic                    wen_q;
  logic                    done_q;
  logic                    err_q;
  logic [numNeurons-1:0]   wsel_q;
  logic [addressWidth-1:0] waddr_q;
  logic [dataWidth-1:0]    wdata_q;

  logic                    cfg_ok_c;
  logic                    hs_c;
  logic                    last_c;
  logic [numNeurons-1:0]   wsel_d;

  // Request validation, handshake, last-word detect and one-hot decode.
  always_comb begin
    cfg_ok_c = (cfg_layer == 32'(layerNo)) && (cfg_neuron < 32'(numNeurons));
    hs_c     = (state_q == LOAD) && s_valid;
    last_c   = (count_q == CntW'(numWeight - 1));
    wsel_d   = '0;
    for (int unsigned i = 0; i < numNeurons; i++) begin
      wsel_d[i] = (cfg_neuron == 32'(i));
    end
  end

  // Control FSM with registered write port and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wsel_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok_c) begin
              wsel_q  <= wsel_d;
              count_q <= '0;
              state_q <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs_c) begin
            wen_q   <= 1'b1;
            waddr_q <= count_q[addressWidth-1:0];
            wdata_q <= s_data;
            count_q <= count_q + CntW'(1);
            if (last_c) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready and busy are decoded from the state register only.
  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD);
  assign wen     = wen_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wsel    = wsel_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Scoreboard bench for weight_mem_loader: a small behavioural model pushes
// each expected write on handshake; the monitor pops it when wen appears.
module tb_weight_mem_loader;

  localparam int unsigned NW = 784;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_layer = 32'd0;
  logic [31:0] cfg_neuron = 32'd0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        s_ready;
  logic        wen;
  logic [63:0] wsel;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  weight_mem_loader #(
    .layerNo(1), .numNeurons(64), .numWeight(NW), .addressWidth(10), .dataWidth(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .wen(wen), .wsel(wsel),
    .waddr(waddr), .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef enum int {M_IDLE, M_LOAD, M_DONE} mstate_e;

  wr_t     sb[$];
  mstate_e m_st   = M_IDLE;
  int      m_cnt  = 0;
  logic    m_err  = 1'b0;
  logic [63:0] m_wsel = 64'd0;

  int n_checks = 0;
  int n_errors = 0;
  int n_wr     = 0;
  int n_done   = 0;
  int n_errp   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    check("s_ready", 64'(s_ready), 64'(m_st == M_LOAD));
    check("busy",    64'(busy),    64'(m_st == M_LOAD));
    check("done",    64'(done),    64'(m_st == M_DONE));
    check("err",     64'(err),     64'(m_err));
    check("wsel",    wsel,         m_wsel);
    check("wen",     64'(wen),     64'(sb.size() != 0));
    if (wen && sb.size() != 0) begin
      e = sb.pop_front();
      check("waddr", 64'(waddr), 64'(e.addr));
      check("wdata", 64'(wdata), 64'(e.data));
      n_wr++;
    end
    if (done) n_done++;
    if (err) n_errp++;
    // Advance the model using the inputs the DUT samples at the next edge.
    m_err = 1'b0;
    if (rst) begin
      m_st   = M_IDLE;
      m_cnt  = 0;
      m_wsel = 64'd0;
    end else begin
      case (m_st)
        M_IDLE: begin
          if (start) begin
            if (cfg_layer == 32'd1 && cfg_neuron < 32'd64) begin
              m_st   = M_LOAD;
              m_cnt  = 0;
              m_wsel = 64'd1 << cfg_neuron[5:0];
            end else begin
              m_err = 1'b1;
            end
          end
        end
        M_LOAD: begin
          if (s_valid) begin
            sb.push_back('{addr: 10'(m_cnt), data: s_data});
            if (m_cnt == int'(NW) - 1) m_st = M_DONE;
            m_cnt++;
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_wr   = 0;
    n_done = 0;
    n_errp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_req(input int layer, input int neuron);
    start      = 1'b1;
    cfg_layer  = 32'(layer);
    cfg_neuron = 32'(neuron);
    tick();
    start = 1'b0;
  endtask

  // Offer n words (data = word index) with given valid density; optional
  // trailing valid cycles and a stray start request at word start_at.
  task automatic stream(input int n, input int pct, input int extra, input int start_at);
    int   idx = 0;
    int   cyc = 0;
    logic hs;
    while (idx < n && cyc < 20000) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = 16'(idx);
      if (idx == start_at) begin
        start      = 1'b1;
        cfg_layer  = 32'd1;
        cfg_neuron = 32'd9;
      end else begin
        start = 1'b0;
      end
      hs = s_valid && s_ready;
      tick();
      cyc++;
      if (hs) idx++;
    end
    start = 1'b0;
    check("stream_words", 64'(idx), 64'(n));
    for (int k = 0; k < extra; k++) begin
      s_valid = 1'b1;
      s_data  = 16'(n + k);
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(2);
    do_reset();
    @(negedge clk);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_wsel",  wsel,       64'd0);
    tick();

    // Normal load, valid held high.
    clear_counts();
    start_req(1, 5);
    stream(NW, 100, 0, -1);
    idle(4);
    check("normal_writes", 64'(n_wr),   64'(NW));
    check("normal_done",   64'(n_done), 64'd1);
    check("normal_wsel",   wsel,        64'd1 << 5);
    check("normal_sb",     64'(sb.size()), 64'd0);

    // Bursty valid.
    clear_counts();
    start_req(1, 17);
    stream(NW, 60, 0, -1);
    idle(4);
    check("bursty_writes", 64'(n_wr),   64'(NW));
    check("bursty_done",   64'(n_done), 64'd1);
    check("bursty_sb",     64'(sb.size()), 64'd0);

    // Rejected requests.
    clear_counts();
    start_req(2, 5);
    idle(3);
    start_req(1, 64);
    idle(3);
    check("reject_errs",   64'(n_errp), 64'd2);
    check("reject_writes", 64'(n_wr),   64'd0);
    check("reject_wsel",   wsel,        64'd1 << 17);

    // Reset in the middle of a load, then a fresh load from address 0.
    clear_counts();
    start_req(1, 40);
    stream(100, 100, 0, -1);
    do_reset();
    idle(3);
    check("midrst_writes", 64'(n_wr),   64'd100);
    check("midrst_done",   64'(n_done), 64'd0);
    check("midrst_busy",   64'(busy),   64'd0);
    clear_counts();
    start_req(1, 40);
    stream(NW, 80, 0, -1);
    idle(4);
    check("reload_writes", 64'(n_wr),   64'(NW));
    check("reload_done",   64'(n_done), 64'd1);

    // Overrun past the last word plus a stray start during LOAD.
    clear_counts();
    start_req(1, 63);
    stream(NW, 100, 10, 300);
    idle(4);
    check("overrun_writes", 64'(n_wr),   64'(NW));
    check("overrun_done",   64'(n_done), 64'd1);
    check("overrun_wsel",   wsel,        64'd1 << 63);
    check("overrun_sb",     64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_mem_loader.md
Name: weight_mem_loader

Overview:
- Write-side companion to the per-neuron weight memories: accepts a stream of weight words and writes them, in address order, into one selected neuron's weight memory of a given layer.
- Sits between the AXI configuration front end, which supplies the words, and the per-neuron weight memories of that layer.
- Drives the memories' write-enable, write address and write data, plus a one-hot neuron select.
- Reports completion and configuration errors back to the front end.

Parameters:
- layerNo, 1, layer index this loader serves; start requests for other layers are rejected.
- numNeurons, 64, number of neuron weight memories in the layer; must be ≤ 64.
- numWeight, 784, weights per neuron; must be ≤ 2**addressWidth.
- addressWidth, 10, weight memory address width.
- dataWidth, 16, weight word width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin loading; sampled only in IDLE.
- cfg_layer  in  32  target layer index, sampled with start.
- cfg_neuron  in  32  target neuron index, sampled with start.
- s_valid  in  1  weight word valid.
- s_data  in  dataWidth  weight word.
- s_ready  out  1  loader can accept a word.
- wen  out  1  memory write enable, gated per neuron by wsel.
- wsel  out  numNeurons  one-hot select of the target neuron memory.
- waddr  out  addressWidth  memory write address.
- wdata  out  dataWidth  memory write data.
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse after the last word has been written.
- err  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset values:
  - State is IDLE; internal word count is 0.
  - s_ready, wen, busy, done and err are 0.
  - wsel, waddr and wdata are 0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - s_ready = 0.
  - start with cfg_layer == layerNo and cfg_neuron < numNeurons: latch wsel = one-hot(cfg_neuron), clear count, go to LOAD next cycle.
  - start with any other cfg_layer or cfg_neuron: err = 1 for the next cycle; stay in IDLE; wsel unchanged.
- LOAD:
  - busy = 1; s_ready = 1, combinational from state only, never dependent on s_valid.
  - Handshake is s_valid & s_ready.
  - On each handshake, next cycle: wen = 1, waddr = count, wdata = s_data. Write latency is 1 cycle from handshake.
  - count then increments.
  - Cycles without a handshake: wen = 0; waddr and wdata hold their last values.
  - Handshake with count == numWeight-1: write that word, then go to DONE. s_ready drops in the cycle after the final handshake, so at most numWeight words are accepted.
  - start is ignored while in LOAD; the latched neuron cannot change mid-load.
- DONE:
  - Lasts exactly one cycle, with done = 1.
  - The wen for the final word is asserted in the same cycle.
  - Returns to IDLE; wsel holds its value until the next accepted start.
- Addressing:
  - count is addressWidth+1 bits wide, so it never wraps; waddr = count[addressWidth-1:0].
  - Addresses run from 0 to numWeight-1, each written exactly once per load.
- Reset mid-load: next cycle is IDLE, count = 0, wen = 0, no done pulse. The partially written memory keeps its contents; reloading overwrites them from address 0.
- s_valid while in IDLE or DONE: ignored, no write.
- start and rst asserted together: rst wins.

Test Plan:
- Normal load: rst, then start with layer 1, neuron 5; stream 784 words 0x0000..0x030F with s_valid held high. Expect:
  - 784 wen pulses, with waddr = data = 0..783.
  - wsel = 1<<5 throughout.
  - done high in the cycle of the 784th wen; busy falls the same cycle.
- Bursty valid: toggle s_valid pseudo-randomly for a full load. Expect:
  - wen only in the cycle after each handshake.
  - waddr strictly increments with no gaps or duplicates.
  - Exactly 784 writes, then one done pulse.
- Rejects: start with layer 2 → err pulse, busy stays 0, no wen. start with layer 1, neuron 64 → err pulse, no wen.
- Reset mid-load: after 100 words, pulse rst. Expect:
  - wen, busy and s_ready are 0 the next cycle, and no done pulse.
  - A fresh start then writes from waddr 0 again.
- Overrun and ignored start: keep s_valid high for 10 words after the last. Expect:
  - s_ready is 0 from the DONE cycle on, and no extra wen.
  - A start issued during LOAD does not change wsel or restart count.
